// File: rtl/uart_writer_pkg.sv
// Shared types and sizing helpers for the UART frame writer.
package uart_writer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SKIP,
        STORE,
        CHECK,
        DONE
    } state_t;

    localparam int DATA_W_DEFAULT = 8;
    localparam int BPW_DEFAULT    = DATA_W_DEFAULT / 8;

    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction

    // Width of a counter that must hold every value 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs a stream of bytes little-endian into DATA_W-bit words; word_valid
// pulses one clock after the byte that completes a word.
module byte_packer
    import uart_writer_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              lane_full,
    output logic              word_valid,
    output logic [DATA_W-1:0] word
);

    localparam int BPW    = bytes_per_word(DATA_W);
    localparam int LANE_W = cnt_width(BPW - 1);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(BPW - 1);

    logic [LANE_W-1:0] lane;
    logic [DATA_W-1:0] pack;
    logic [DATA_W-1:0] next_word;

    assign lane_full = byte_valid && (lane == LANE_LAST);

    always_comb begin
        next_word = pack;
        for (int i = 0; i < BPW; i++) begin
            if (lane == LANE_W'(i)) next_word[8*i +: 8] = byte_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane       <= '0;
            pack       <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else if (clear) begin
            lane       <= '0;
            pack       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= lane_full;
            if (byte_valid) begin
                if (lane_full) begin
                    lane <= '0;
                    pack <= '0;
                    word <= next_word;
                end else begin
                    lane <= lane + 1'b1;
                    pack <= next_word;
                end
            end
        end
    end

endmodule

// File: rtl/uart_frame_writer.sv
// Strips a fixed header from a UART byte stream and writes NUM_WORDS packed words
// to RAM from address 0. Optional trailer checksum: define UART_FRAME_CHECKSUM_EN.
module uart_frame_writer
    import uart_writer_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int HDR_BYTES = 16,
    parameter int NUM_WORDS = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              chk_err
);

    // rx_valid is a one-cycle strobe with no back-pressure: every strobe seen in
    // SKIP/STORE/CHECK is consumed on that clock; strobes in IDLE/DONE are dropped.

    localparam int HDR_W = cnt_width(HDR_BYTES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
    localparam logic [HDR_W-1:0]  HDR_LAST  = HDR_W'((HDR_BYTES > 0) ? HDR_BYTES - 1 : 0);
    localparam logic [HDR_W-1:0]  HDR_MAX   = HDR_W'(HDR_BYTES);

    state_t            state;
    state_t            state_d;
    logic [HDR_W-1:0]  hdr_cnt;
    logic [ADDR_W-1:0] word_cnt;
    logic              last_taken;   // final word complete, its write not yet issued
    logic              arm;
    logic              pack_valid;
    logic              lane_full;
    logic              word_valid;

    assign arm        = start && (state == IDLE || state == DONE);
    assign pack_valid = rx_valid && (state == STORE) && !last_taken;
    assign mem_we     = word_valid;
    assign busy       = (state == SKIP) || (state == STORE) || (state == CHECK);
    assign done       = (state == DONE);

    byte_packer #(.DATA_W(DATA_W)) u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (arm),
        .byte_valid (pack_valid),
        .byte_data  (rx_data),
        .lane_full  (lane_full),
        .word_valid (word_valid),
        .word       (mem_wdata)
    );

`ifdef UART_FRAME_CHECKSUM_EN
    logic [7:0] sum;
    logic       chk_err_q;
    logic       chk_byte;

    // A trailer arriving in the final write cycle is already the checksum byte.
    assign chk_byte = rx_valid && ((state == CHECK) || (state == STORE && last_taken));
    assign chk_err  = chk_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum       <= '0;
            chk_err_q <= 1'b0;
        end else if (arm) begin
            sum       <= '0;
            chk_err_q <= 1'b0;
        end else begin
            if (pack_valid) sum <= sum + rx_data;
            if (chk_byte) chk_err_q <= (sum != rx_data);
        end
    end
`else
    assign chk_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE, DONE: if (start) state_d = (HDR_BYTES == 0) ? STORE : SKIP;
            SKIP:       if (rx_valid && hdr_cnt == HDR_LAST) state_d = STORE;
            STORE: begin
                if (last_taken && word_valid) begin
`ifdef UART_FRAME_CHECKSUM_EN
                    state_d = chk_byte ? DONE : CHECK;
`else
                    state_d = DONE;
`endif
                end
            end
            CHECK:      if (rx_valid) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hdr_cnt    <= '0;
            word_cnt   <= '0;
            last_taken <= 1'b0;
            mem_addr   <= '0;
        end else if (arm) begin
            hdr_cnt    <= '0;
            word_cnt   <= '0;
            last_taken <= 1'b0;
            mem_addr   <= '0;
        end else begin
            if (state == SKIP && rx_valid && hdr_cnt != HDR_MAX) hdr_cnt <= hdr_cnt + 1'b1;
            if (lane_full) begin
                word_cnt <= word_cnt + 1'b1;
                if (word_cnt == LAST_ADDR) last_taken <= 1'b1;
            end
            if (word_valid) mem_addr <= (mem_addr == LAST_ADDR) ? '0 : mem_addr + 1'b1;
        end
    end

endmodule
